// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM state, default widths and queue entry.
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned-PC reporting).
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RESP,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
        logic                    misalign;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// PC, instruction-memory and decode-side signals of the fetch unit.
// FETCH_ALIGN_CHECK_EN adds the per-entry instr_misalign flag.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] pc;
    logic              pc_hold;
    logic              redirect;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              instr_misalign;
`endif

    // master = the fetch unit; slave = PC logic, memory and decode around it
    modport master (
        input  pc, redirect, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        output pc_hold, imem_req, imem_addr, instr_valid, instr, instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
        , instr_misalign
`endif
    );

    modport slave (
        output pc, redirect, imem_gnt, imem_rvalid, imem_rdata, instr_ready,
        input  pc_hold, imem_req, imem_addr, instr_valid, instr, instr_pc
`ifdef FETCH_ALIGN_CHECK_EN
        , instr_misalign
`endif
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Synchronous circular FIFO with push/pop/flush; head is visible combinationally.
// Simultaneous push and pop is accepted even when full.
module fetch_queue #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_count = r_count;
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches the word at the current PC (one request in flight) and queues {pc, instr} for decode.
// FETCH_ALIGN_CHECK_EN: misaligned PCs are queued with instr=0 and a misalign flag, no memory access.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = FETCH_ADDR_W,
    parameter int unsigned DATA_W = FETCH_DATA_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic               clk,
    input  logic               startin,
    instr_fetch_unit_if.master fetch
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
`ifdef FETCH_ALIGN_CHECK_EN
        logic              misalign;
`endif
    } entry_t;

    fetch_state_t      r_state;
    fetch_state_t      w_next_state;
    logic [ADDR_W-1:0] r_req_pc;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_outstanding;
    logic              w_space;
    logic              w_issue_ok;
    logic              w_req;
    logic              w_accept;
    logic              w_mis_push;
    logic              w_push;
    logic              w_pop;
    entry_t            w_push_entry;
    entry_t            w_head;

    // The space check counts the in-flight slot so a response always has room.
    assign w_outstanding = (r_state != IDLE);
    assign w_space       = (w_count + CNT_W'(w_outstanding)) < CNT_W'(DEPTH);
    assign w_issue_ok    = (r_state == IDLE) && w_space && !fetch.redirect && !startin;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_mis_push = w_issue_ok && (fetch.pc[1:0] != 2'b00);
    assign w_req      = w_issue_ok && !w_mis_push;
`else
    assign w_mis_push = 1'b0;
    assign w_req      = w_issue_ok;
`endif
    assign w_accept = w_req && fetch.imem_gnt;

    always_ff @(posedge clk) begin
        if (startin) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (startin)       r_req_pc <= '0;
        else if (w_accept) r_req_pc <= fetch.pc;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      if (w_accept) w_next_state = WAIT_RESP;
            WAIT_RESP: begin
                if (fetch.imem_rvalid)   w_next_state = IDLE;
                else if (fetch.redirect) w_next_state = DROP;
            end
            DROP:      if (fetch.imem_rvalid) w_next_state = IDLE;
            default:   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        fetch.imem_req  = w_req;
        fetch.imem_addr = fetch.pc;
        fetch.pc_hold   = !(w_accept || w_mis_push);
        w_push          = ((r_state == WAIT_RESP) && fetch.imem_rvalid && !fetch.redirect)
                          || w_mis_push;
        w_pop           = !w_empty && fetch.instr_ready && !fetch.redirect;
        w_push_entry.pc    = r_req_pc;
        w_push_entry.instr = fetch.imem_rdata;
`ifdef FETCH_ALIGN_CHECK_EN
        w_push_entry.misalign = 1'b0;
        if (w_mis_push) begin
            w_push_entry.pc       = fetch.pc;
            w_push_entry.instr    = '0;
            w_push_entry.misalign = 1'b1;
        end
`endif
    end

    fetch_queue #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_queue (
        .clk        (clk),
        .i_rst      (startin),
        .i_push     (w_push),
        .i_push_data(w_push_entry),
        .i_pop      (w_pop),
        .i_flush    (fetch.redirect),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign fetch.instr_valid = !w_empty;
    assign fetch.instr       = w_head.instr;
    assign fetch.instr_pc    = w_head.pc;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch.instr_misalign = w_head.misalign;
`endif

    a_no_push_overflow: assert property (@(posedge clk) disable iff (startin)
        !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: driver + memory model feed a queue of expected
// decode entries; a separate monitor pops and compares at every decode-side handshake.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic startin = 1'b1;

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .startin(startin),
        .fetch  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    fetch_entry_t exp_q[$];

    // stimulus knobs
    int      gnt_pct, ready_pct, redir_pct, rst_pct, dmin, dmax;
    bit      rst_req, force_redir_on_wait, force_rst_on_wait, use_fixed;
    logic [AW-1:0] forced_target;
    logic [DW-1:0] fixed_data;

    // reference state: PC register, in-flight fetch, memory response scheduler
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] acc_pc;
    bit            outst, alive, mem_pend;
    int            mem_wait;
    logic [DW-1:0] mem_data;
    bit            prev_rst = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit            do_rst, do_redir, rv, acc, hold, exp_req, exp_mis;
        logic [AW-1:0] tgt;
        @(negedge clk);
        do_rst = rst_req || (force_rst_on_wait && outst);
        if (do_rst && force_rst_on_wait && outst) force_rst_on_wait = 1'b0;
        do_redir = 1'b0;
        tgt = AW'($urandom) & ~AW'(3);
        if (!do_rst) begin
            if (force_redir_on_wait && outst) begin
                do_redir = 1'b1;
                tgt = forced_target;
                force_redir_on_wait = 1'b0;
            end else if ($urandom_range(99) < redir_pct) begin
                do_redir = 1'b1;
            end
        end
        rv = mem_pend && (mem_wait == 0);
        startin          = do_rst;
        bus.redirect     = do_redir;
        bus.pc           = pc_reg;
        bus.imem_gnt     = !mem_pend && ($urandom_range(99) < gnt_pct);
        bus.imem_rvalid  = rv;
        bus.imem_rdata   = rv ? mem_data : DW'($urandom);
        bus.instr_ready  = ($urandom_range(99) < ready_pct);
        #1;
        exp_req = !do_rst && !outst && !do_redir && (exp_q.size() < DEPTH);
        exp_mis = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_mis = exp_req && (pc_reg[1:0] != 2'b00);
        exp_req = exp_req && !exp_mis;
`endif
        chk("imem_req", bus.imem_req, exp_req);
        if (exp_req) chk("imem_addr", bus.imem_addr, pc_reg);
        chk("pc_hold", bus.pc_hold, !((exp_req && bus.imem_gnt) || exp_mis));
        acc  = bus.imem_req && bus.imem_gnt;
        hold = bus.pc_hold;
        @(posedge clk);
        if (do_rst) begin
            exp_q.delete();
            outst = 1'b0;
            alive = 1'b0;
        end else begin
            if (do_redir) begin
                exp_q.delete();
                alive = 1'b0;
            end
            if (outst && rv) begin
                if (alive) exp_q.push_back('{pc: acc_pc, instr: mem_data, misalign: 1'b0});
                outst = 1'b0;
            end
            if (exp_mis) exp_q.push_back('{pc: pc_reg, instr: '0, misalign: 1'b1});
            if (acc) begin
                outst  = 1'b1;
                alive  = 1'b1;
                acc_pc = pc_reg;
            end
        end
        if (rv) mem_pend = 1'b0;
        else if (mem_pend) mem_wait--;
        if (acc) begin
            mem_pend = 1'b1;
            mem_wait = int'($urandom_range(dmax, dmin)) - 1;
            mem_data = use_fixed ? fixed_data : DW'($urandom);
        end
        if (do_redir) pc_reg = tgt;
        else if (!hold && !do_rst) pc_reg = pc_reg + AW'(4);
    endtask

    // decode-side monitor
    always @(negedge clk) begin
        #2;
        chk("instr_valid", bus.instr_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("instr_pc", bus.instr_pc, exp_q[0].pc);
            chk("instr", bus.instr, exp_q[0].instr);
`ifdef FETCH_ALIGN_CHECK_EN
            chk("instr_misalign", bus.instr_misalign, exp_q[0].misalign);
`endif
            if (bus.instr_ready && !bus.redirect && !startin) void'(exp_q.pop_front());
        end else if (prev_rst) begin
            chk("rst_instr", bus.instr, '0);
            chk("rst_instr_pc", bus.instr_pc, '0);
        end
        prev_rst = startin;
    end

    task automatic drain();
        gnt_pct = 0;
        ready_pct = 100;
        redir_pct = 0;
        repeat (6) step();
    endtask

    initial begin
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; rst_pct = 0;
        dmin = 1; dmax = 1;
        rst_req = 1'b1; force_redir_on_wait = 1'b0; force_rst_on_wait = 1'b0;
        use_fixed = 1'b1; fixed_data = 32'h2002_0004;
        forced_target = '0;
        pc_reg = '0; acc_pc = '0; outst = 1'b0; alive = 1'b0; mem_pend = 1'b0;
        mem_wait = 0; mem_data = '0;
        bus.pc = '0; bus.redirect = 1'b0; bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0; bus.instr_ready = 1'b0;

        // minimum-latency fetch from pc=0
        repeat (2) step();
        rst_req = 1'b0;
        repeat (6) step();

        // grant withheld for three cycles at pc=4
        rst_req = 1'b1; pc_reg = 32'h4; gnt_pct = 0;
        step();
        rst_req = 1'b0;
        repeat (3) step();
        gnt_pct = 100;
        repeat (4) step();

        // decode stalled: queue fills, request withheld, then FIFO order across wrap
        use_fixed = 1'b0; ready_pct = 0;
        repeat (8) step();
        ready_pct = 100;
        repeat (8) step();

        // redirect while waiting for a slow response
        drain();
        dmin = 3; dmax = 3; gnt_pct = 100;
        forced_target = 32'h40; force_redir_on_wait = 1'b1;
        repeat (10) step();

        // reset while waiting; the late response must be ignored
        drain();
        gnt_pct = 100; force_rst_on_wait = 1'b1;
        repeat (10) step();

`ifdef FETCH_ALIGN_CHECK_EN
        rst_req = 1'b1; pc_reg = 32'h6;
        step();
        rst_req = 1'b0;
        repeat (3) step();
        rst_req = 1'b1; pc_reg = '0;
        step();
        rst_req = 1'b0;
`endif

        // randomized traffic
        for (int unsigned blk = 0; blk < 15; blk++) begin
            gnt_pct   = int'($urandom_range(100, 20));
            ready_pct = int'($urandom_range(100, 0));
            redir_pct = int'($urandom_range(15, 0));
            rst_pct   = (blk % 5 == 4) ? 2 : 0;
            dmin      = int'($urandom_range(2, 1));
            dmax      = int'($urandom_range(4, dmin));
            for (int unsigned i = 0; i < 200; i++) begin
                rst_req = ($urandom_range(99) < rst_pct);
                step();
            end
        end
        rst_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
